pwm_decoder: RTL and testbench
==============================

Name: pwm_decoder

Overview:
Receive-side counterpart to the team's PWM generator. Measures an incoming PWM waveform and reports high time and period in clk cycles once per PWM period. The input is asynchronous to clk and is synchronised internally. Sits on the sensing/loopback side of a PWM link, e.g. servo feedback or generator self-check.

Parameters:
CNT_W, 16, width of the high-time/period counters and outputs; saturation value MAX = 2^CNT_W-1
SYNC_STAGES, 2, number of synchroniser flops on pwm_in (minimum 2)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high; clears all state
enable  input  1  1 = measure; 0 = go idle, counters cleared, outputs held
pwm_in  input  1  PWM waveform, asynchronous
high_time  output  CNT_W  last complete high width, in clk cycles
period  output  CNT_W  last complete period (rise to rise), in clk cycles
meas_valid  output  1  single-cycle pulse when high_time/period update
timeout  output  1  sticky; no edge seen for MAX cycles
stuck_level  output  1  synchronised pwm_in level captured when timeout set
duty_out  output  8  floor(high_time*256/period); see DUTY_CALC_EN
duty_valid  output  1  single-cycle pulse when duty_out updates

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0, synchroniser flops 0.
- Sync: pwm_in -> SYNC_STAGES flops -> s; one extra flop s_d. rise = s & ~s_d; fall = ~s & s_d. Rise and fall cannot coincide in the same cycle.
- Sync latency shifts the edges in time but not the measured widths.
- States: IDLE, ARM, HIGH, LOW.
- IDLE: entered when enable=0 from any state, effective next cycle. Counters are 0; outputs hold their last values. Leaves to ARM when enable=1.
- ARM: waits for rise. If enable rises while pwm_in is already high, the first measurement starts at the next true rising edge.
- On rise in ARM: pcnt<=1, hcnt<=1, go to HIGH.
- HIGH: every cycle without fall, pcnt++ and hcnt++. On fall: pcnt++, hcnt holds, go to LOW.
- LOW: every cycle without rise, pcnt++.
- On rise in LOW: high_time<=hcnt, period<=pcnt, meas_valid=1 for that one cycle, timeout<=0, pcnt<=1, hcnt<=1, go to HIGH. Measurements are back-to-back with no dead period.
- Consequence: a high of H cycles and low of L cycles gives high_time=H and period=H+L. A 1-cycle high gives high_time=1.
- Timeout: in HIGH or LOW, if pcnt==MAX and no edge this cycle: timeout<=1, stuck_level<=s, go to ARM. Counters never wrap. high_time and period hold. timeout clears only on the next meas_valid or on reset.
- 0% / 100% duty inputs therefore report as timeout with stuck_level 0 or 1.
- Reset mid-measurement: partial counts are discarded. The first meas_valid after reset needs one full rise-to-rise interval after a rise seen in ARM.

Optional Feature:
DUTY_CALC_EN
- Defined:
  - Sequential restoring divider computes duty_out = floor(high_time*256/period).
  - Quotient is always <=255 because high_time < period.
  - Operands are latched on meas_valid. Eight iteration cycles follow; duty_valid pulses exactly 9 cycles after meas_valid.
  - If a new meas_valid arrives while a division is in flight, the division restarts with the new operands and the old result is never published.
  - enable=0 aborts the division; duty_out holds.
- Undefined: no divider is built; duty_out and duty_valid are tied 0, and the ports remain present.

Test Plan:
1. Drive pwm_in from the team's PWM generator on the same clk with duty=100 -> from the second rise on, each meas_valid shows high_time=100, period=256. With DUTY_CALC_EN, duty_out=100 nine cycles after each meas_valid.
2. Generator duty=10, then switched to 255 -> high_time 10/period 256, then 255/256 (1-cycle low measured correctly). duty_out 10 then 255.
3. Hand-driven pwm_in high 3 / low 5 repeating -> high_time=3, period=8, duty_out=96. Then high 1 / low 1 -> high_time=1, period=2, duty_out=128. The 9-cycle divider is restarted by each new meas_valid and completes only after the final measurement.
4. CNT_W=10, pwm_in held 0 after one full period -> timeout=1 and stuck_level=0 exactly 1023 cycles after the last rise. Outputs hold, state is ARM. Resuming 3/5 clears timeout at the next meas_valid.
5. Assert reset for 1 cycle mid-HIGH -> all outputs 0 immediately. The first meas_valid appears only after a new full rise-to-rise interval.
6. enable=1 while pwm_in already high, then deassert enable mid-LOW -> no measurement from the partial pulse. Deassert gives IDLE next cycle with outputs held, and no meas_valid while enable=0.

Source files
------------

// File: rtl/pwm_decoder.sv
// PWM receiver: measures high time and period of an async pwm_in.
// Define DUTY_CALC_EN to build the sequential duty-cycle divider.
module pwm_decoder #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_time,
  output logic [CNT_W-1:0] period,
  output logic             meas_valid,
  output logic             timeout,
  output logic             stuck_level,
  output logic [7:0]       duty_out,
  output logic             duty_valid
);

  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] sync_q;
  logic s, s_d, rise, fall;

  logic [CNT_W-1:0] pcnt, pcnt_n;
  logic [CNT_W-1:0] hcnt, hcnt_n;
  logic [CNT_W-1:0] ht_n, per_n;
  logic [CNT_W-1:0] pinc;
  logic mv_n, to_n, st_n;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;
  assign pinc = (pcnt == MAX) ? MAX : pcnt + ONE;

  // Synchronise pwm_in and keep one delayed copy for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      s_d    <= s;
    end
  end

  // State, counters and measurement outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pcnt        <= '0;
      hcnt        <= '0;
      high_time   <= '0;
      period      <= '0;
      meas_valid  <= 1'b0;
      timeout     <= 1'b0;
      stuck_level <= 1'b0;
    end else begin
      state       <= state_n;
      pcnt        <= pcnt_n;
      hcnt        <= hcnt_n;
      high_time   <= ht_n;
      period      <= per_n;
      meas_valid  <= mv_n;
      timeout     <= to_n;
      stuck_level <= st_n;
    end
  end

  // Next-state: count high/period, publish on rise, trap dead lines.
  always_comb begin
    state_n = state;
    pcnt_n  = pcnt;
    hcnt_n  = hcnt;
    ht_n    = high_time;
    per_n   = period;
    mv_n    = 1'b0;
    to_n    = timeout;
    st_n    = stuck_level;
    if (!enable) begin
      state_n = IDLE;
      pcnt_n  = '0;
      hcnt_n  = '0;
    end else begin
      unique case (state)
        IDLE: state_n = ARM;
        ARM: begin
          if (rise) begin
            pcnt_n  = ONE;
            hcnt_n  = ONE;
            state_n = HIGH;
          end
        end
        HIGH: begin
          if (fall) begin
            pcnt_n  = pinc;
            state_n = LOW;
          end else if (pcnt == MAX) begin
            to_n    = 1'b1;
            st_n    = s;
            pcnt_n  = '0;
            hcnt_n  = '0;
            state_n = ARM;
          end else begin
            pcnt_n = pcnt + ONE;
            hcnt_n = hcnt + ONE;
          end
        end
        LOW: begin
          if (rise) begin
            ht_n    = hcnt;
            per_n   = pcnt;
            mv_n    = 1'b1;
            to_n    = 1'b0;
            pcnt_n  = ONE;
            hcnt_n  = ONE;
            state_n = HIGH;
          end else if (pcnt == MAX) begin
            to_n    = 1'b1;
            st_n    = s;
            pcnt_n  = '0;
            hcnt_n  = '0;
            state_n = ARM;
          end else begin
            pcnt_n = pcnt + ONE;
          end
        end
      endcase
    end
  end

`ifdef DUTY_CALC_EN
  logic             busy;
  logic [3:0]       dcnt;
  logic [CNT_W-1:0] rem;
  logic [CNT_W-1:0] den;
  logic [6:0]       quo;
  logic [CNT_W:0]   rem2, rem_w;
  logic             ge;
  logic [7:0]       q_nx;

  assign rem2  = {rem, 1'b0};
  assign ge    = rem2 >= {1'b0, den};
  assign rem_w = ge ? rem2 - {1'b0, den} : rem2;
  assign q_nx  = {quo, ge};

  // Restoring divider: high_time*256/period, one quotient bit per cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy       <= 1'b0;
      dcnt       <= '0;
      rem        <= '0;
      den        <= '0;
      quo        <= '0;
      duty_out   <= '0;
      duty_valid <= 1'b0;
    end else begin
      duty_valid <= 1'b0;
      if (!enable) begin
        busy <= 1'b0;
      end else if (meas_valid) begin
        rem  <= high_time;
        den  <= period;
        quo  <= '0;
        dcnt <= 4'd8;
        busy <= 1'b1;
      end else if (busy) begin
        rem  <= rem_w[CNT_W-1:0];
        quo  <= q_nx[6:0];
        dcnt <= dcnt - 4'd1;
        if (dcnt == 4'd1) begin
          busy       <= 1'b0;
          duty_out   <= q_nx;
          duty_valid <= 1'b1;
        end
      end
    end
  end
`else
  assign duty_out   = '0;
  assign duty_valid = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_decoder.sv
// Directed bench for pwm_decoder: table of PWM patterns plus
// timeout, reset, enable and divider-abort sequences.
module tb_pwm_decoder;

  localparam int W = 10;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic         pwm_in;
  logic [W-1:0] high_time;
  logic [W-1:0] period;
  logic         meas_valid;
  logic         timeout;
  logic         stuck_level;
  logic [7:0]   duty_out;
  logic         duty_valid;

  pwm_decoder #(.CNT_W(W), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .pwm_in     (pwm_in),
    .high_time  (high_time),
    .period     (period),
    .meas_valid (meas_valid),
    .timeout    (timeout),
    .stuck_level(stuck_level),
    .duty_out   (duty_out),
    .duty_valid (duty_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int h;
    int l;
    int reps;
    int nm;
    int ht;
    int per;
    int duty;
  } vec_t;

  vec_t vecs[5];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int n_meas = 0;
  int n_duty = 0;
  int meas_cyc = 0;
  int duty_cyc = 0;
  int to_cyc = 0;
  logic to_prev = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (meas_valid) begin
      n_meas++;
      meas_cyc = cyc;
    end
    if (duty_valid) begin
      n_duty++;
      duty_cyc = cyc;
    end
    if (timeout && !to_prev) to_cyc = cyc;
    to_prev = timeout;
  end

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input int h, input int l, input int reps);
    repeat (reps) begin
      pwm_in = 1'b1;
      tick(h);
      pwm_in = 1'b0;
      tick(l);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ht"}, int'(high_time), 0);
    chk({tag, "_per"}, int'(period), 0);
    chk({tag, "_mv"}, int'(meas_valid), 0);
    chk({tag, "_to"}, int'(timeout), 0);
    chk({tag, "_stuck"}, int'(stuck_level), 0);
    chk({tag, "_duty"}, int'(duty_out), 0);
    chk({tag, "_dv"}, int'(duty_valid), 0);
  endtask

  initial begin
    int m0;
    int d0;

    vecs[0] = '{h: 100, l: 156, reps: 3, nm: 2, ht: 100, per: 256, duty: 100};
    vecs[1] = '{h: 10,  l: 246, reps: 3, nm: 3, ht: 10,  per: 256, duty: 10};
    vecs[2] = '{h: 255, l: 1,   reps: 3, nm: 3, ht: 255, per: 256, duty: 255};
    vecs[3] = '{h: 3,   l: 5,   reps: 4, nm: 4, ht: 3,   per: 8,   duty: 96};
    vecs[4] = '{h: 1,   l: 1,   reps: 6, nm: 6, ht: 1,   per: 2,   duty: 128};

    reset  = 1'b1;
    enable = 1'b1;
    pwm_in = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("rst");
    @(posedge clk);
    #1 reset = 1'b0;
    tick(2);

    for (int i = 0; i < 5; i++) begin
      m0 = n_meas;
      d0 = n_duty;
      drive(vecs[i].h, vecs[i].l, vecs[i].reps);
      tick(14);
      chk($sformatf("v%0d_nmeas", i), n_meas - m0, vecs[i].nm);
      chk($sformatf("v%0d_ht", i), int'(high_time), vecs[i].ht);
      chk($sformatf("v%0d_per", i), int'(period), vecs[i].per);
      chk($sformatf("v%0d_to", i), int'(timeout), 0);
`ifdef DUTY_CALC_EN
      chk($sformatf("v%0d_duty", i), int'(duty_out), vecs[i].duty);
      chk($sformatf("v%0d_dlat", i), duty_cyc - meas_cyc, 9);
      if (vecs[i].h + vecs[i].l < 9)
        chk($sformatf("v%0d_dcnt", i), n_duty - d0, 1);
`else
      chk($sformatf("v%0d_duty", i), int'(duty_out), 0);
      chk($sformatf("v%0d_dcnt", i), n_duty - d0, 0);
`endif
    end

    // line stuck low
    m0 = n_meas;
    tick(1100);
    chk("tlo_to", int'(timeout), 1);
    chk("tlo_stuck", int'(stuck_level), 0);
    chk("tlo_lat", to_cyc - meas_cyc, 1023);
    chk("tlo_ht", int'(high_time), 1);
    chk("tlo_per", int'(period), 2);
    chk("tlo_nmeas", n_meas - m0, 0);

    // resume: first rise only arms, next one clears timeout
    m0 = n_meas;
    drive(3, 5, 1);
    chk("res_to_held", int'(timeout), 1);
    chk("res_nmeas1", n_meas - m0, 0);
    drive(3, 5, 2);
    tick(14);
    chk("res_to_clr", int'(timeout), 0);
    chk("res_ht", int'(high_time), 3);
    chk("res_per", int'(period), 8);
    chk("res_nmeas", n_meas - m0, 2);

    // line stuck high
    m0 = n_meas;
    pwm_in = 1'b1;
    tick(1100);
    chk("thi_to", int'(timeout), 1);
    chk("thi_stuck", int'(stuck_level), 1);
    chk("thi_lat", to_cyc - meas_cyc, 1023);
    chk("thi_ht", int'(high_time), 3);
    chk("thi_per", int'(period), 22);
    chk("thi_nmeas", n_meas - m0, 1);

    // reset in the middle of a high phase
    pwm_in = 1'b0;
    tick(5);
    drive(3, 5, 2);
    pwm_in = 1'b1;
    tick(3);
    reset = 1'b1;
    @(negedge clk);
    chk_zero("mrst");
    @(posedge clk);
    #1 reset = 1'b0;
    tick(2);
    pwm_in = 1'b0;
    tick(5);
    drive(3, 5, 3);
    tick(14);
    chk("mrst_ht", int'(high_time), 3);
    chk("mrst_per", int'(period), 8);

    // enable while high, then drop enable mid-low
    enable = 1'b0;
    pwm_in = 1'b1;
    tick(3);
    enable = 1'b1;
    tick(3);
    m0 = n_meas;
    pwm_in = 1'b0;
    tick(4);
    pwm_in = 1'b1;
    tick(2);
    pwm_in = 1'b0;
    tick(2);
    enable = 1'b0;
    tick(2);
    drive(2, 4, 3);
    tick(14);
    chk("en_nmeas", n_meas - m0, 0);
    chk("en_ht", int'(high_time), 3);
    chk("en_per", int'(period), 8);
    chk("en_to", int'(timeout), 0);
`ifdef DUTY_CALC_EN
    chk("en_duty", int'(duty_out), 96);
`else
    chk("en_duty", int'(duty_out), 0);
`endif

    // restarts by close measurements, then abort by enable
    enable = 1'b1;
    tick(2);
    m0 = n_meas;
    d0 = n_duty;
    drive(2, 4, 3);
    pwm_in = 1'b1;
    tick(5);
    enable = 1'b0;
    tick(15);
    chk("ab_nmeas", n_meas - m0, 3);
    chk("ab_ht", int'(high_time), 2);
    chk("ab_per", int'(period), 6);
    chk("ab_dcnt", n_duty - d0, 0);
`ifdef DUTY_CALC_EN
    chk("ab_duty", int'(duty_out), 96);
`else
    chk("ab_duty", int'(duty_out), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
